// File: rtl/cluster_event_latch_map_if.sv
// Register-port bundle for cluster_event_latch_map: request/grant plus a
// one-cycle-later response. The master drives the request; the slave answers.
interface cluster_event_latch_map_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  gnt;
    logic                  r_valid;
    logic [31:0]           rdata;

    modport master (
        output req, wen, addr, wdata,
        input  gnt, r_valid, rdata
    );

    modport slave (
        input  req, wen, addr, wdata,
        output gnt, r_valid, rdata
    );
endinterface

// File: rtl/cluster_event_latch_map.sv
// Per-core sticky event capture with software mask and a register port.
// Optional per-core coalesced-event counters are enabled by CLUSTER_EVENT_OVF_CNT_EN.
module cluster_event_latch_map #(
    parameter int NB_CORES   = 8,
    parameter int NB_CL_EVT  = 3,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NB_CORES-1:0][7:0]            sw_events_i,
    input  logic [NB_CORES-1:0][1:0]            dma_events_i,
    input  logic [NB_CORES-1:0][1:0]            timer_events_i,
    input  logic [NB_CORES-1:0][3:0]            acc_events_i,
    input  logic [NB_CORES-1:0]                 barrier_events_i,
    input  logic [NB_CORES-1:0]                 mutex_events_i,
    input  logic [NB_CORES-1:0]                 dispatch_events_i,
    input  logic [NB_CORES-1:0][NB_CL_EVT-1:0]  cluster_events_i,
    input  logic                                periph_fifo_event_i,
    input  logic [NB_CORES-1:0][31:0]           evt_clr_i,
    output logic [NB_CORES-1:0][31:0]           events_mapped_o,
    cluster_event_latch_map_if.slave            bus
);

    localparam int CIDX_W = ADDR_WIDTH - 4;

    typedef enum logic [1:0] {
        REG_MASK    = 2'd0,
        REG_PENDING = 2'd1,
        REG_OVF     = 2'd2,
        REG_RSVD    = 2'd3
    } reg_sel_e;

    reg_sel_e                   reg_sel;
    logic [CIDX_W-1:0]          core_idx;
    logic [NB_CORES-1:0]        core_hit;
    logic                       addr_unused;

    logic [NB_CORES-1:0][31:0]  raw;
    logic [NB_CORES-1:0][31:0]  clr;
    logic [NB_CORES-1:0][31:0]  pending_d, pending_q;
    logic [NB_CORES-1:0][31:0]  mask_d, mask_q;
    logic [NB_CORES-1:0][15:0]  ovf_view;
    logic [31:0]                rd_val;

    assign reg_sel     = reg_sel_e'(bus.addr[3:2]);
    assign core_idx    = bus.addr[ADDR_WIDTH-1:4];
    assign addr_unused = ^bus.addr[1:0];
    assign bus.gnt     = bus.req;

    // Out-of-range core indices match no core, so they read 0 and write nothing.
    always_comb begin
        for (int c = 0; c < NB_CORES; c++) begin
            core_hit[c] = bus.req && (core_idx == CIDX_W'(c));
        end
    end

    // Reserved bits are never driven here, so they can never set in pending.
    always_comb begin
        raw = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            raw[c][7:0]              = sw_events_i[c];
            raw[c][9:8]              = dma_events_i[c];
            raw[c][11:10]            = timer_events_i[c];
            raw[c][15:12]            = acc_events_i[c];
            raw[c][16]               = barrier_events_i[c];
            raw[c][17]               = mutex_events_i[c];
            raw[c][18]               = dispatch_events_i[c];
            raw[c][22 +: NB_CL_EVT]  = cluster_events_i[c];
            raw[c][27]               = periph_fifo_event_i;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        clr    = evt_clr_i;
        mask_d = mask_q;
        for (int c = 0; c < NB_CORES; c++) begin
            if (core_hit[c] && bus.wen) begin
                if (reg_sel == REG_PENDING) clr[c] = clr[c] | bus.wdata;
                if (reg_sel == REG_MASK)    mask_d[c] = bus.wdata;
            end
            // Set after clear: a new event always survives a simultaneous clear.
            pending_d[c] = (pending_q[c] & ~clr[c]) | raw[c];
        end
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            if (core_hit[c]) begin
                case (reg_sel)
                    REG_MASK:    rd_val = mask_q[c];
                    REG_PENDING: rd_val = pending_q[c];
                    REG_OVF:     rd_val = {16'h0000, ovf_view[c]};
                    default:     rd_val = '0;
                endcase
            end
        end
    end

    // NOTE: these per-core arrays are plain flops, not RAM, so they take the
    // async reset like any other state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q       <= '0;
            mask_q          <= '1;
            events_mapped_o <= '0;
            bus.r_valid     <= 1'b0;
            bus.rdata       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading the
            // pre-edge values, independent of statement order.
            pending_q       <= pending_d;
            mask_q          <= mask_d;
            events_mapped_o <= pending_d & mask_d;
            bus.r_valid     <= bus.req;
            bus.rdata       <= bus.req ? rd_val : 32'h0;
        end
    end

`ifdef CLUSTER_EVENT_OVF_CNT_EN
    logic [NB_CORES-1:0][15:0] ovf_q;
    logic [NB_CORES-1:0]       coalesce;
    logic [NB_CORES-1:0]       ovf_rd;

    // A coalesce is a raw arrival onto a pending bit that is not being cleared.
    always_comb begin
        for (int c = 0; c < NB_CORES; c++) begin
            coalesce[c] = |(raw[c] & pending_q[c] & ~clr[c]);
            ovf_rd[c]   = core_hit[c] && !bus.wen && (reg_sel == REG_OVF);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= '0;
        end else begin
            for (int c = 0; c < NB_CORES; c++) begin
                if (ovf_rd[c]) begin
                    ovf_q[c] <= {15'h0000, coalesce[c]};
                end else if (coalesce[c] && (ovf_q[c] != 16'hFFFF)) begin
                    ovf_q[c] <= ovf_q[c] + 16'd1;
                end
            end
        end
    end

    assign ovf_view = ovf_q;
`else
    assign ovf_view = '0;
`endif

endmodule

// File: doc/cluster_event_latch_map.md
# cluster_event_latch_map

Registered, programmable successor to the cluster's combinational event map. It sits between the cluster event sources (event-unit internals, DMA, timer, HW accelerators, external cluster events, peripheral FIFO) and each core's event-unit input. It captures single-cycle event pulses into per-core sticky pending registers and applies a per-core software mask. It presents a registered 32-bit level-style event vector per core, and software reaches the masks and pending bits through a small peripheral register port.

## Interface
- NB_CORES, 8, number of cores / event vectors (1..16)
- NB_CL_EVT, 3, external cluster events per core, mapped at bits [22+NB_CL_EVT-1:22] (1..5)
- ADDR_WIDTH, 10, byte address width of the register port (≥ clog2(NB_CORES)+4)
- clk_i  in  1  cluster clock
- rst_ni  in  1  asynchronous active-low reset
- sw_events_i  in  [NB_CORES][8]  SW event pulses → bits [7:0]
- dma_events_i  in  [NB_CORES][2]  → bits [9:8]
- timer_events_i  in  [NB_CORES][2]  → bits [11:10]
- acc_events_i  in  [NB_CORES][4]  → bits [15:12]
- barrier_events_i / mutex_events_i / dispatch_events_i  in  [NB_CORES] each  → bits 16 / 17 / 18
- cluster_events_i  in  [NB_CORES][NB_CL_EVT]  → bits [22+NB_CL_EVT-1:22]
- periph_fifo_event_i  in  1  broadcast to bit 27 of every core
- evt_clr_i  in  [NB_CORES][32]  per-core bit clear from the core's event unit (pulse)
- events_mapped_o  out  [NB_CORES][32]  registered pending & mask
- req_i, wen_i (1 = write), addr_i [ADDR_WIDTH], wdata_i [32]  in  register-port request
- gnt_o  out  1  grant; r_valid_o  out  1  response; rdata_o  out  32  read data

## Operation
- Raw vector per core: sources placed at the bit positions above. Bits 19–21, bits [26:22+NB_CL_EVT], and bits 28–31 are reserved and hardwired 0 in pending.
- Pending register per core, 32 bits: next = (pending & ~clr) | raw.
  - clr = evt_clr_i[c] | (bus W1C data when the PENDING write targets core c).
  - Set wins over clear in the same cycle. No event is ever lost.
- Mask register per core, 32 bits, RW, reset 0xFFFF_FFFF. Masked bits still latch in pending.
- events_mapped_o[c] = pending_q[c] & mask_q[c], driven from flops (mask update registered too).
- Register map, core c at byte offset c*16; addr_i[1:0] ignored:
  - +0x0 MASK: RW.
  - +0x4 PENDING: read returns pending_q. A write clears the bits set in wdata (W1C).
  - +0x8 OVF: RO, clear on read. Present only with the macro, otherwise reads 0.
  - +0xC: reads 0, writes ignored.
  - Core index ≥ NB_CORES: reads 0, writes ignored, still granted.
- Handshake: gnt_o = req_i (always granted, combinational). The write takes effect at the next edge. r_valid_o pulses exactly one cycle after every granted request, for writes too. rdata_o holds the value sampled at the grant edge and is 0 when r_valid_o is low.

## Timing
- Reset: all pending 0, all masks 0xFFFF_FFFF, OVF 0, events_mapped_o 0, r_valid_o 0, rdata_o 0.
- Event pulse sampled at edge N → pending bit and events_mapped_o bit high after edge N (visible in cycle N+1). Latency is 1 cycle.
- evt_clr_i sampled at edge N → bit low from cycle N+1, unless re-raised in the same cycle.
- MASK write granted at edge N → new mask affects events_mapped_o from cycle N+1.
- Back-to-back requests are allowed every cycle. Responses pipeline one per cycle.
- Asynchronous reset mid-transaction drops any pending response: r_valid_o goes to 0 immediately.

## Configuration
- CLUSTER_EVENT_OVF_CNT_EN defined:
  - One 16-bit saturating counter per core.
  - Increments by 1 per cycle in which any raw bit arrives while that pending bit is already 1 and not cleared that cycle (coalesced event).
  - Saturates at 0xFFFF.
  - OVF read returns the count zero-extended and clears the counter. If a coalesce occurs in the same cycle as the read, the counter becomes 1.
- Not defined: no counter logic; OVF reads 0.

## Test plan
- Reset, then idle: events_mapped_o all 0; MASK reads of every core return 0xFFFF_FFFF; r_valid_o 0.
- Pulse sw_events_i[2] = 0x05 for 1 cycle: events_mapped_o[2] = 0x0000_0005 from the next cycle and stays there. evt_clr_i[2] = 0x1 → 0x0000_0004 one cycle later.
- Write MASK core 1 = 0x0000_FF00, then pulse dma_events_i[1] = 2'b11 and sw_events_i[1] = 0xFF: output = 0x0000_0300, and PENDING read = 0x0000_03FF. Writing PENDING with 0x0000_0100 → output 0x0000_0200.
- Same cycle: barrier_events_i[0] = 1 and evt_clr_i[0] bit16 = 1 → bit 16 remains 1. periph_fifo_event_i pulse → bit 27 set on all NB_CORES.
- With CLUSTER_EVENT_OVF_CNT_EN: pulse timer_events_i[3][0] three times with no clear → OVF core 3 reads 2, then reads 0. Drive 70000 coalescing cycles → reads 0xFFFF.
- Read at address core index NB_CORES → rdata 0, r_valid_o high one cycle after grant. Assert rst_ni low the cycle after a request → r_valid_o stays 0.
